// File: rtl/icache_nway_if.sv
// icache_nway_if: fetch-side and memory-side signals of the N-way icache.
// The slave modport is the cache; the master modport is the datapath plus
// memory controller side. ICACHE_STATS_EN adds the hitcount/misscount outputs.
interface icache_nway_if;
    // datapath fetch port
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        inv;
    // memory controller instruction port
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hitcount;
    logic [31:0] misscount;
`endif

    modport slave (
        input  imemREN, imemaddr, inv, iwait, iload,
`ifdef ICACHE_STATS_EN
        output hitcount, misscount,
`endif
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, inv, iwait, iload,
`ifdef ICACHE_STATS_EN
        input  hitcount, misscount,
`endif
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_nway.sv
// icache_nway: read-only N-way set-associative instruction cache for one CPU.
// Lookup is combinational in IDLE; a miss latches tag/set/victim and FILL
// streams WORDS words from memory. inv clears every valid bit and aborts a fill.
// Optional macro ICACHE_STATS_EN adds wrapping hit/miss counters.
module icache_nway #(
    parameter int CPUID = 0,
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 2
) (
    input  logic          CLK,
    input  logic          nRST,
    icache_nway_if.slave  bus
);
    localparam int WL = $clog2(WORDS);
    localparam int SL = $clog2(SETS);
    localparam int AL = $clog2(WAYS);
    localparam int TW = 30 - WL - SL;
    localparam int WW = (WL > 0) ? WL : 1;
    localparam int AW = (AL > 0) ? AL : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    if (CPUID < 0 || SETS < 2 || (SETS & (SETS - 1)) != 0 ||
        WAYS < 1 || (WAYS & (WAYS - 1)) != 0 ||
        WORDS < 1 || (WORDS & (WORDS - 1)) != 0) begin : g_param_check
        $error("icache_nway: illegal parameter set");
    end

    logic [WAYS-1:0] r_valid [SETS];
    logic [TW-1:0]   r_tag   [SETS][WAYS];
    logic [31:0]     r_data  [SETS][WAYS][WORDS];
    logic [AW-1:0]   r_ptr   [SETS];

    logic [0:0]      r_state;
    logic [WW-1:0]   r_cnt;
    logic [TW-1:0]   r_tag_l;
    logic [SL-1:0]   r_set_l;
    logic [AW-1:0]   r_way_l;

    logic [WW-1:0]   w_word;
    logic [SL-1:0]   w_set;
    logic [TW-1:0]   w_tag;
    logic            w_hit_any;
    logic [AW-1:0]   w_hit_way;
    logic            w_inv_found;
    logic [AW-1:0]   w_inv_way;
    logic [AW-1:0]   w_victim;
    logic            w_lookup;
    logic            w_ihit;
    logic            w_miss_go;
    logic            w_fill;
    logic            w_last;
    logic [31:0]     w_iaddr;
    logic            w_unused;

    assign w_word   = WW'((bus.imemaddr >> 2) & 32'(WORDS - 1));
    assign w_set    = SL'(bus.imemaddr >> (2 + WL));
    assign w_tag    = TW'(bus.imemaddr >> (2 + WL + SL));
    assign w_unused = &{1'b0, bus.imemaddr[1:0]};

    // Way search: matching way for a hit, lowest invalid way for the victim.
    always_comb begin
        w_hit_any   = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (r_valid[w_set][w] && r_tag[w_set][w] == w_tag) begin
                w_hit_any = 1'b1;
                w_hit_way = AW'(w);
            end
            if (!r_valid[w_set][w] && !w_inv_found) begin
                w_inv_found = 1'b1;
                w_inv_way   = AW'(w);
            end
        end
        w_victim = w_inv_found ? w_inv_way : r_ptr[w_set];
    end

    assign w_lookup  = (r_state == ST_IDLE) && bus.imemREN && !bus.inv;
    assign w_ihit    = w_lookup && w_hit_any;
    assign w_miss_go = w_lookup && !w_hit_any;
    assign w_fill    = (r_state == ST_FILL);
    assign w_last    = (r_cnt == WW'(WORDS - 1));
    // {tag, set, word, 2'b00} built arithmetically so WORDS=1 needs no slice
    assign w_iaddr   = (32'({r_tag_l, r_set_l}) << (2 + WL)) | (32'(r_cnt) << 2);

    assign bus.ihit     = w_ihit;
    assign bus.imemload = w_ihit ? r_data[w_set][w_hit_way][w_word] : '0;
    assign bus.iREN     = w_fill;
    assign bus.iaddr    = w_fill ? w_iaddr : '0;

    // Control: FSM, word counter, valid bits and victim pointers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_tag_l <= '0;
            r_set_l <= '0;
            r_way_l <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_ptr[s]   <= '0;
            end
        end else if (bus.inv) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
            end
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_miss_go) begin
                        r_tag_l <= w_tag;
                        r_set_l <= w_set;
                        r_way_l <= w_victim;
                        r_state <= ST_FILL;
                    end
                end
                default: begin
                    if (!bus.iwait) begin
                        if (w_last) begin
                            r_valid[r_set_l][r_way_l] <= 1'b1;
                            r_ptr[r_set_l] <= AW'((32'(r_way_l) + 32'd1) % 32'(WAYS));
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Line storage: data words and tag written by accepted fill beats.
    always_ff @(posedge CLK) begin
        if (w_fill && !bus.iwait && !bus.inv) begin
            r_data[r_set_l][r_way_l][r_cnt] <= bus.iload;
            if (w_last) begin
                r_tag[r_set_l][r_way_l] <= r_tag_l;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hitcnt;
    logic [31:0] r_misscnt;

    // Hit cycles and IDLE->FILL transitions, wrapping, untouched by inv.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_hitcnt  <= '0;
            r_misscnt <= '0;
        end else begin
            if (w_ihit)    r_hitcnt  <= r_hitcnt + 32'd1;
            if (w_miss_go) r_misscnt <= r_misscnt + 32'd1;
        end
    end

    assign bus.hitcount  = r_hitcnt;
    assign bus.misscount = r_misscnt;
`endif
endmodule

// File: tb/tb_icache_nway.sv
// tb_icache_nway: scoreboard bench for icache_nway (SETS=8, WAYS=2, WORDS=2).
// Requests push the expected word and hit/miss latency; a monitor pops on ihit.
// The memory model checks every accepted fill address against expectations.
module tb_icache_nway;
    localparam int SETS      = 8;
    localparam int WAYS      = 2;
    localparam int WORDS     = 2;
    localparam int BLK_BYTES = WORDS * 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          hit_now;
        int unsigned issue;
    } exp_t;

    logic CLK = 1'b0;
    logic nRST;

    icache_nway_if bus ();

    icache_nway #(.CPUID(0), .SETS(SETS), .WAYS(WAYS), .WORDS(WORDS)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc = 0;
    int unsigned last_acc = 0;
    int unsigned acc_count = 0;

    exp_t        expq[$];
    logic [31:0] fillq[$];

    // reference model: block numbers per line, victim pointer per set
    bit          m_valid [SETS][WAYS];
    int unsigned m_blk   [SETS][WAYS];
    int unsigned m_ptr   [SETS];

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
    endfunction

    function automatic void model_inv();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    endfunction

    // returns 1 on hit; on miss installs the block the way the cache should
    function automatic bit model_access(input logic [31:0] a);
        int unsigned blk, s, v;
        bit found;
        blk = a / BLK_BYTES;
        s   = blk % SETS;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_blk[s][w] == blk) return 1'b1;
        found = 1'b0;
        v = m_ptr[s];
        for (int w = 0; w < WAYS; w++)
            if (!m_valid[s][w] && !found) begin
                found = 1'b1;
                v = w;
            end
        m_valid[s][v] = 1'b1;
        m_blk[s][v]   = blk;
        m_ptr[s]      = (v + 1) % WAYS;
        return 1'b0;
    endfunction

    function automatic void push_fill(input logic [31:0] a);
        logic [31:0] base;
        base = a & ~32'(BLK_BYTES - 1);
        for (int k = 0; k < WORDS; k++) fillq.push_back(base + 32'(4 * k));
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge CLK) cyc++;

    // memory: iwait high 2 cycles per word, data = addr ^ 0xA5A5_0000
    initial begin
        int ph;
        logic [31:0] ea;
        ph = 0;
        bus.iwait = 1'b1;
        bus.iload = '0;
        forever begin
            @(negedge CLK);
            if (bus.iREN === 1'b1) begin
                bus.iload = bus.iaddr ^ 32'hA5A5_0000;
                if (ph < 2) begin
                    bus.iwait = 1'b1;
                    ph++;
                end else begin
                    bus.iwait = 1'b0;
                    ph = 0;
                    last_acc = cyc;
                    acc_count++;
                    tests++;
                    if (fillq.size() == 0) begin
                        fails++;
                        $display("FAIL fill_addr: iaddr=%h accepted, none expected", bus.iaddr);
                    end else begin
                        ea = fillq.pop_front();
                        if (bus.iaddr !== ea) begin
                            fails++;
                            $display("FAIL fill_addr: got %h expected %h", bus.iaddr, ea);
                        end
                    end
                end
            end else begin
                bus.iwait = 1'b1;
                ph = 0;
            end
        end
    end

    // monitor: every ihit pops one expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (bus.ihit === 1'b1) begin
                tests++;
                if (expq.size() == 0) begin
                    fails++;
                    $display("FAIL ihit_unexpected: ihit=1 addr=%h, none expected", bus.imemaddr);
                end else begin
                    e = expq.pop_front();
                    if (bus.imemload !== e.data) begin
                        fails++;
                        $display("FAIL imemload @%h: got %h expected %h", e.addr, bus.imemload, e.data);
                    end
                    tests++;
                    if (e.hit_now ? (cyc != e.issue) : (cyc != last_acc + 1)) begin
                        fails++;
                        $display("FAIL latency @%h: ihit in cycle %0d, expected %0d (hit_now=%0d)",
                                 e.addr, cyc, e.hit_now ? e.issue : last_acc + 1, e.hit_now);
                    end
                    tests++;
                    if (bus.iREN !== 1'b0) begin
                        fails++;
                        $display("FAIL iren_on_hit @%h: got %b expected 0", e.addr, bus.iREN);
                    end
                end
            end
        end
    end

    // called at posedge+1; exp_hit < 0 lets the model decide
    task automatic do_req(input logic [31:0] a, input int exp_hit);
        exp_t e;
        bit mh;
        int n;
        mh = model_access(a);
        e.addr    = a;
        e.data    = a ^ 32'hA5A5_0000;
        e.hit_now = (exp_hit < 0) ? mh : (exp_hit != 0);
        e.issue   = cyc;
        if (!e.hit_now) push_fill(a);
        expq.push_back(e);
        bus.imemaddr = a;
        bus.imemREN  = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (bus.ihit !== 1'b1 && n < 60);
        if (bus.ihit !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL timeout @%h: no ihit within 60 cycles", a);
            void'(expq.pop_back());
            fillq.delete();
        end
        @(posedge CLK);
        #1;
        bus.imemREN = 1'b0;
    endtask

    task automatic do_reset();
        bus.imemREN = 1'b0;
        bus.inv     = 1'b0;
        nRST        = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        model_reset();
        fillq.delete();
    endtask

    task automatic wait_accept();
        int unsigned start;
        int n;
        start = acc_count;
        n = 0;
        while (acc_count == start && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (acc_count == start) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: no fill word accepted within 40 cycles");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [31:0] a;
        bus.imemREN  = 1'b0;
        bus.imemaddr = '0;
        bus.inv      = 1'b0;
        nRST = 1'b1;
        #1 nRST = 1'b0;
        #2;
        check32("reset_ihit", 32'(bus.ihit), 32'd0);
        check32("reset_iREN", 32'(bus.iREN), 32'd0);
        check32("reset_iaddr", bus.iaddr, 32'd0);
        check32("reset_imemload", bus.imemload, 32'd0);
        do_reset();

        // read 0x40 after reset, then the sibling word hits
        do_req(32'h40, 0);
        do_req(32'h44, 1);

        // three blocks competing for set 0
        do_reset();
        do_req(32'h000, 0);
        do_req(32'h040, 0);
        do_req(32'h080, 0);
        do_req(32'h040, 1);
        do_req(32'h000, 0);

        // inv forces ihit low on a resident line, then everything misses
        bus.imemaddr = 32'h080;
        bus.imemREN  = 1'b1;
        bus.inv      = 1'b1;
        @(negedge CLK);
        check32("inv_cycle_ihit", 32'(bus.ihit), 32'd0);
        @(posedge CLK);
        #1;
        bus.inv     = 1'b0;
        bus.imemREN = 1'b0;
        model_inv();
        do_req(32'h040, 0);
        do_req(32'h080, 0);

        // inv after the first fill word of 0x100 abandons the fill
        push_fill(32'h100);
        bus.imemaddr = 32'h100;
        bus.imemREN  = 1'b1;
        wait_accept();
        @(posedge CLK);
        #1;
        check32("fill_active_iREN", 32'(bus.iREN), 32'd1);
        bus.inv     = 1'b1;
        bus.imemREN = 1'b0;
        @(posedge CLK);
        #1;
        bus.inv = 1'b0;
        check32("inv_abort_iREN", 32'(bus.iREN), 32'd0);
        model_inv();
        fillq.delete();
        do_req(32'h100, 0);

        // asynchronous reset in the middle of a fill of 0x200
        push_fill(32'h200);
        bus.imemaddr = 32'h200;
        bus.imemREN  = 1'b1;
        repeat (3) @(negedge CLK);
        check32("prereset_iREN", 32'(bus.iREN), 32'd1);
        #1 nRST = 1'b0;
        #1;
        check32("midfill_reset_iREN", 32'(bus.iREN), 32'd0);
        check32("midfill_reset_ihit", 32'(bus.ihit), 32'd0);
        bus.imemREN = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        model_reset();
        fillq.delete();
        do_req(32'h200, 0);

        // randomized traffic over 4 tags x 2 sets x 2 words, occasional inv
        for (int i = 0; i < 100; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                bus.inv = 1'b1;
                @(posedge CLK);
                #1;
                bus.inv = 1'b0;
                model_inv();
            end else begin
                a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 1)) << 3) |
                    (32'($urandom_range(0, 1)) << 2);
                do_req(a, -1);
            end
        end

        // counter sequence: one miss, two hit cycles
        do_reset();
        do_req(32'h40, 0);
        do_req(32'h44, 1);
`ifdef ICACHE_STATS_EN
        check32("misscount", bus.misscount, 32'd1);
        check32("hitcount", bus.hitcount, 32'd2);
`endif

        repeat (3) @(posedge CLK);
        check32("expq_drained", 32'(expq.size()), 32'd0);
        check32("fillq_drained", 32'(fillq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
